mul_reservation_station: RTL and testbench
==========================================

Name: mul_reservation_station

Overview:
- Issue-side front end of the Tomasulo multiplier path.
- Holds pending multiply instructions and snoops the common data bus (CDB) for missing operands.
- Dispatches one ready instruction at a time to Multiplier_Unit over its MUL_Tag_ip/Source_Reg1/Source_Reg2 interface.
- Frees each entry when the result for its tag appears on the CDB.

Parameters:
- NUM_ENTRIES, 2, number of reservation-station entries (1..4).
- TAG_BASE, 3'd4, tag of entry 0; entry i owns tag TAG_BASE+i. Tag 3'b000 is reserved as "operand available / no op".
- DATA_W, 8, operand and result width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decoder presents a MUL instruction.
- issue_ready  out  1  at least one entry free (combinational).
- issue_tag  out  3  tag that will be assigned to the presented instruction (lowest free entry; 000 when full).
- issue_q1, issue_q2  in  3  producer tags of operands; 000 = value valid.
- issue_v1, issue_v2  in  DATA_W  operand values (used when matching q = 000).
- cdb_valid  in  1  CDB broadcast this cycle.
- cdb_tag  in  3  broadcasting tag.
- cdb_data  in  DATA_W  broadcast value.
- MUL_Status  in  1  multiplier busy (1) / idle (0).
- MUL_Tag_ip  out  3  dispatch tag to multiplier; 000 = no dispatch (registered).
- Source_Reg1, Source_Reg2  out  DATA_W  dispatched operands (registered).
- rs_busy  out  NUM_ENTRIES  per-entry occupied flags.

Behaviour:
- Reset (async, rst_n=0): all entries invalid; FSM=IDLE; MUL_Tag_ip=000; Source_Reg1/2=0; rs_busy=0.
- Entry fields: busy, dispatched, q1, v1, q2, v2.
- Allocation:
  - When issue_valid && issue_ready on a rising edge, the lowest-index free entry is written.
  - Same-cycle bypass: if cdb_valid and cdb_tag==issue_qN (qN≠000), store cdb_data and qN=000.
  - issue_valid while full is ignored; the decoder must hold the instruction.
- Snoop: every cycle, for each busy entry with qN≠000 and cdb_valid && cdb_tag==qN, latch cdb_data into vN and clear qN. Both operands may capture in the same cycle.
- Ready: busy && !dispatched && q1==000 && q2==000, evaluated on registered state. A freshly allocated entry is eligible the cycle after allocation at the earliest.
- Dispatch FSM:
  - IDLE: if MUL_Status==0 and any entry is ready, select the lowest-index ready entry; next edge registers MUL_Tag_ip=entry tag and Source_Reg1/2=v1/v2, marks the entry dispatched, and goes to ISSUE.
  - ISSUE: exactly one cycle; MUL_Tag_ip valid. Next edge: MUL_Tag_ip=000, Source_Reg1/2 hold their values, go to WAIT.
  - WAIT: wait until cdb_valid && cdb_tag==in-flight tag. On that edge, free the entry (busy=0, dispatched=0) and return to IDLE.
  - Minimum dispatch-to-dispatch spacing is CDB latency + 2 cycles.
- Simultaneous events:
  - A freeing broadcast and a new allocation into the same entry on one edge: the allocation wins, and the entry becomes busy with the new instruction.
  - A broadcast that frees one entry also satisfies operand snoops of other entries (dependent MUL chain).
  - issue_ready reflects pre-edge state; an entry freed this cycle is not reallocatable until next cycle.
- MUL_Status==1 in IDLE: no dispatch; ready entries keep waiting.
- CDB tags outside this station's range affect operands only, never freeing.
- Reset mid-operation: the in-flight instruction is dropped; MUL_Tag_ip=000 immediately (asynchronous).

Test Plan:
- Reset, then issue q1=q2=000, v1=5, v2=2 with MUL_Status=0 → issue_tag=4; two cycles later MUL_Tag_ip=4 for exactly 1 cycle, Source_Reg1=5, Source_Reg2=2; CDB(tag 4, data 10) → rs_busy=00.
- Issue q1=3'd2 (pending), v2=15 → no dispatch; CDB(tag 2, data 1) → next dispatch MUL_Tag_ip=4, Source_Reg1=1, Source_Reg2=15.
- Fill both entries (tags 4, 5) → issue_ready=0; third issue_valid is ignored; CDB(tag 4) frees entry 0 → issue_ready=1, issue_tag=4.
- Entry 1 has q1=4 (chain): CDB(tag 4, data 10) frees entry 0 and sets entry 1 v1=10 on the same edge → entry 1 dispatches with Source_Reg1=10.
- Allocation with issue_q1=2 while cdb_valid, cdb_tag=2, cdb_data=7 → entry stores v1=7, q1=000; dispatches without further broadcast.
- Hold MUL_Status=1 with a ready entry → MUL_Tag_ip stays 000; drop MUL_Status → dispatch. Assert rst_n=0 during ISSUE → MUL_Tag_ip=000 and rs_busy=00 without a clock edge.

Source files
------------

// File: rtl/mul_reservation_station.sv
// -----------------------------------------------------------------------------
// mul_reservation_station
//
// Issue-side front end of the Tomasulo multiplier path. Holds pending multiply
// instructions and snoops the common data bus (CDB) for missing operands. It
// dispatches one ready instruction at a time to the multiplier and frees that
// entry when the result for its tag is broadcast on the CDB.
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   issue_valid            decoder presents a MUL instruction
//   issue_ready            at least one entry free (combinational)
//   issue_tag              tag the presented instruction will get (000 = full)
//   issue_q1/q2            producer tags of the operands (000 = value valid)
//   issue_v1/v2            operand values, used where the matching q is 000
//   cdb_valid/tag/data     common data bus broadcast
//   MUL_Status             multiplier busy (1) / idle (0)
//   MUL_Tag_ip             registered dispatch tag (000 = no dispatch)
//   Source_Reg1/2          registered dispatched operands
//   rs_busy                per-entry occupied flags
// -----------------------------------------------------------------------------
module mul_reservation_station #(
    parameter int         NUM_ENTRIES = 2,
    parameter logic [2:0] TAG_BASE    = 3'd4,
    parameter int         DATA_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    output logic [2:0]             issue_tag,
    input  logic [2:0]             issue_q1,
    input  logic [2:0]             issue_q2,
    input  logic [DATA_W-1:0]      issue_v1,
    input  logic [DATA_W-1:0]      issue_v2,
    input  logic                   cdb_valid,
    input  logic [2:0]             cdb_tag,
    input  logic [DATA_W-1:0]      cdb_data,
    input  logic                   MUL_Status,
    output logic [2:0]             MUL_Tag_ip,
    output logic [DATA_W-1:0]      Source_Reg1,
    output logic [DATA_W-1:0]      Source_Reg2,
    output logic [NUM_ENTRIES-1:0] rs_busy
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    function automatic logic [2:0] tag_of(input logic [IDX_W-1:0] idx);
        return TAG_BASE + 3'(idx);
    endfunction

    // Entry storage
    logic [NUM_ENTRIES-1:0] busy;
    logic [NUM_ENTRIES-1:0] dispatched;
    logic [2:0]             q1 [NUM_ENTRIES];
    logic [2:0]             q2 [NUM_ENTRIES];
    logic [DATA_W-1:0]      v1 [NUM_ENTRIES];
    logic [DATA_W-1:0]      v2 [NUM_ENTRIES];

    state_t           state, state_next;
    logic [IDX_W-1:0] inflight_idx;

    // Selection logic
    logic [NUM_ENTRIES-1:0] ready;
    logic                   alloc_found;
    logic [IDX_W-1:0]       alloc_idx;
    logic                   ready_found;
    logic [IDX_W-1:0]       ready_idx;
    logic                   do_alloc;
    logic                   do_dispatch;
    logic                   do_free;
    logic                   bypass1;
    logic                   bypass2;

    // NOTE: every signal driven from always_comb gets a default before any
    // conditional assignment, so no path leaves it unassigned (no latch).
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        ready_found = 1'b0;
        ready_idx   = '0;
        ready       = '0;
        // Scan high-to-low so the last hit is the lowest index.
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            ready[i] = busy[i] && !dispatched[i] && (q1[i] == 3'b000) && (q2[i] == 3'b000);
            if (!busy[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
            if (ready[i]) begin
                ready_found = 1'b1;
                ready_idx   = IDX_W'(i);
            end
        end
    end

    assign issue_ready = alloc_found;
    assign issue_tag   = alloc_found ? tag_of(alloc_idx) : 3'b000;
    assign rs_busy     = busy;

    assign do_alloc    = issue_valid && alloc_found;
    assign do_dispatch = (state == S_IDLE) && !MUL_Status && ready_found;
    assign do_free     = (state == S_WAIT) && cdb_valid && (cdb_tag == tag_of(inflight_idx));

    // Same-cycle CDB bypass for an operand still pending at issue time.
    assign bypass1 = cdb_valid && (issue_q1 != 3'b000) && (cdb_tag == issue_q1);
    assign bypass2 = cdb_valid && (issue_q2 != 3'b000) && (cdb_tag == issue_q2);

    // Dispatch FSM: next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (do_dispatch) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (do_free) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Entry array, dispatch registers. Later assignments in this block take
    // priority: snoop, then free, then allocation (allocation wins).
    // NOTE: the entry array is reset in full; it is small, and resetting the
    // operand fields keeps dispatched values deterministic after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= '0;
            dispatched   <= '0;
            inflight_idx <= '0;
            MUL_Tag_ip   <= 3'b000;
            Source_Reg1  <= '0;
            Source_Reg2  <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                q1[i] <= 3'b000;
                q2[i] <= 3'b000;
                v1[i] <= '0;
                v2[i] <= '0;
            end
        end else begin
            // Operand snoop on every busy entry; both operands may capture.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (busy[i] && cdb_valid) begin
                    if ((q1[i] != 3'b000) && (cdb_tag == q1[i])) begin
                        v1[i] <= cdb_data;
                        q1[i] <= 3'b000;
                    end
                    if ((q2[i] != 3'b000) && (cdb_tag == q2[i])) begin
                        v2[i] <= cdb_data;
                        q2[i] <= 3'b000;
                    end
                end
            end

            if (do_dispatch) begin
                MUL_Tag_ip              <= tag_of(ready_idx);
                Source_Reg1             <= v1[ready_idx];
                Source_Reg2             <= v2[ready_idx];
                dispatched[ready_idx]   <= 1'b1;
                inflight_idx            <= ready_idx;
            end else if (state == S_ISSUE) begin
                // Tag is a one-cycle pulse; operands stay put.
                MUL_Tag_ip <= 3'b000;
            end

            if (do_free) begin
                busy[inflight_idx]       <= 1'b0;
                dispatched[inflight_idx] <= 1'b0;
            end

            if (do_alloc) begin
                busy[alloc_idx]       <= 1'b1;
                dispatched[alloc_idx] <= 1'b0;
                q1[alloc_idx]         <= bypass1 ? 3'b000 : issue_q1;
                v1[alloc_idx]         <= bypass1 ? cdb_data : issue_v1;
                q2[alloc_idx]         <= bypass2 ? 3'b000 : issue_q2;
                v2[alloc_idx]         <= bypass2 ? cdb_data : issue_v2;
            end
        end
    end

endmodule

// File: tb/tb_mul_reservation_station.sv
// -----------------------------------------------------------------------------
// tb_mul_reservation_station
//
// Directed scenarios followed by a randomized run. A behavioural model of the
// station (array of entry records plus an in-flight index) predicts every
// output; the bench also plays the multiplier, answering each dispatch with a
// CDB broadcast of the product after a random latency.
// -----------------------------------------------------------------------------
module tb_mul_reservation_station;

    localparam int N  = 2;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_valid;
    logic          issue_ready;
    logic [2:0]    issue_tag;
    logic [2:0]    issue_q1, issue_q2;
    logic [DW-1:0] issue_v1, issue_v2;
    logic          cdb_valid;
    logic [2:0]    cdb_tag;
    logic [DW-1:0] cdb_data;
    logic          mul_status;
    logic [2:0]    mul_tag_ip;
    logic [DW-1:0] source_reg1, source_reg2;
    logic [N-1:0]  rs_busy;

    mul_reservation_station #(
        .NUM_ENTRIES(N),
        .TAG_BASE   (3'd4),
        .DATA_W     (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_tag  (issue_tag),
        .issue_q1   (issue_q1),
        .issue_q2   (issue_q2),
        .issue_v1   (issue_v1),
        .issue_v2   (issue_v2),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .MUL_Status (mul_status),
        .MUL_Tag_ip (mul_tag_ip),
        .Source_Reg1(source_reg1),
        .Source_Reg2(source_reg2),
        .rs_busy    (rs_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          busy;
        bit          disp;
        bit [2:0]    q1;
        bit [DW-1:0] v1;
        bit [2:0]    q2;
        bit [DW-1:0] v2;
    } ment_t;

    ment_t       m [N];
    int          m_inflight;   // entry in the multiplier, -1 when none
    bit          m_pulse;      // dispatch tag currently visible
    bit [2:0]    m_tag_ip;
    bit [DW-1:0] m_s1, m_s2;

    function automatic int lowest_free();
        for (int i = 0; i < N; i++) if (!m[i].busy) return i;
        return -1;
    endfunction

    function automatic bit [N-1:0] m_busy_vec();
        bit [N-1:0] b = '0;
        for (int i = 0; i < N; i++) b[i] = m[i].busy;
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m[i] = '{0, 0, 3'd0, '0, 3'd0, '0};
        m_inflight = -1;
        m_pulse    = 0;
        m_tag_ip   = 3'd0;
        m_s1       = '0;
        m_s2       = '0;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_step();
        ment_t n [N];
        int    f;
        int    nf;
        n  = m;
        nf = m_inflight;
        f  = lowest_free();
        for (int i = 0; i < N; i++) begin
            if (m[i].busy && cdb_valid) begin
                if (m[i].q1 != 0 && m[i].q1 == cdb_tag) begin n[i].v1 = cdb_data; n[i].q1 = 0; end
                if (m[i].q2 != 0 && m[i].q2 == cdb_tag) begin n[i].v2 = cdb_data; n[i].q2 = 0; end
            end
        end
        if (m_inflight < 0) begin
            if (!mul_status) begin
                for (int i = 0; i < N; i++) begin
                    if (m[i].busy && !m[i].disp && m[i].q1 == 0 && m[i].q2 == 0) begin
                        m_tag_ip  = 3'(4 + i);
                        m_s1      = m[i].v1;
                        m_s2      = m[i].v2;
                        n[i].disp = 1;
                        nf        = i;
                        m_pulse   = 1;
                        break;
                    end
                end
            end
        end else if (m_pulse) begin
            m_tag_ip = 3'd0;
            m_pulse  = 0;
        end else if (cdb_valid && cdb_tag == 3'(4 + m_inflight)) begin
            n[m_inflight].busy = 0;
            n[m_inflight].disp = 0;
            nf = -1;
        end
        if (issue_valid && f >= 0) begin
            n[f].busy = 1;
            n[f].disp = 0;
            if (cdb_valid && issue_q1 != 0 && cdb_tag == issue_q1) begin n[f].q1 = 0; n[f].v1 = cdb_data; end
            else begin n[f].q1 = issue_q1; n[f].v1 = issue_v1; end
            if (cdb_valid && issue_q2 != 0 && cdb_tag == issue_q2) begin n[f].q2 = 0; n[f].v2 = cdb_data; end
            else begin n[f].q2 = issue_q2; n[f].v2 = issue_v2; end
        end
        m          = n;
        m_inflight = nf;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clr();
        issue_valid = 0; issue_q1 = 0; issue_q2 = 0; issue_v1 = 0; issue_v2 = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    endtask

    task automatic set_issue(input bit [2:0] a_q1, input bit [DW-1:0] a_v1,
                             input bit [2:0] a_q2, input bit [DW-1:0] a_v2);
        issue_valid = 1; issue_q1 = a_q1; issue_v1 = a_v1; issue_q2 = a_q2; issue_v2 = a_v2;
    endtask

    task automatic set_cdb(input bit [2:0] t, input bit [DW-1:0] d);
        cdb_valid = 1; cdb_tag = t; cdb_data = d;
    endtask

    // Check combinational outputs, step the model, clock, check registered outputs.
    task automatic tick();
        int f;
        f = lowest_free();
        check("issue_ready", issue_ready, (f >= 0) ? 1 : 0);
        check("issue_tag", issue_tag, (f >= 0) ? 3'(4 + f) : 3'd0);
        model_step();
        @(posedge clk);
        #1;
        cycle++;
        check("MUL_Tag_ip", mul_tag_ip, m_tag_ip);
        check("Source_Reg1", source_reg1, m_s1);
        check("Source_Reg2", source_reg2, m_s2);
        check("rs_busy", rs_busy, m_busy_vec());
    endtask

    task automatic do_reset();
        rst_n = 0;
        clr();
        mul_status = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_tag_ip", mul_tag_ip, 3'd0);
        check("reset_src1", source_reg1, 0);
        check("reset_src2", source_reg2, 0);
        check("reset_busy", rs_busy, 0);
        rst_n = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    // Randomized-phase multiplier emulation
    int          res_due;
    bit [2:0]    res_tag;
    bit [DW-1:0] res_data;

    initial begin
        do_reset();
        check("reset_ready", issue_ready, 1);
        check("reset_issue_tag", issue_tag, 3'd4);

        // 1: simple ready instruction, dispatch pulse, free on CDB
        set_issue(0, 8'd5, 0, 8'd2);
        check("t1_issue_tag", issue_tag, 3'd4);
        tick();
        clr();
        tick();
        check("t1_disp_tag", mul_tag_ip, 3'd4);
        check("t1_src1", source_reg1, 8'd5);
        check("t1_src2", source_reg2, 8'd2);
        tick();
        check("t1_pulse_end", mul_tag_ip, 3'd0);
        check("t1_src1_hold", source_reg1, 8'd5);
        tick();
        set_cdb(3'd4, 8'd10);
        tick();
        clr();
        check("t1_freed", rs_busy, 2'b00);

        // 2: pending operand resolved by CDB snoop
        set_issue(3'd2, 8'd0, 0, 8'd15);
        tick();
        clr();
        repeat (3) begin
            tick();
            check("t2_no_disp", mul_tag_ip, 3'd0);
        end
        set_cdb(3'd2, 8'd1);
        tick();
        clr();
        tick();
        check("t2_disp_tag", mul_tag_ip, 3'd4);
        check("t2_src1", source_reg1, 8'd1);
        check("t2_src2", source_reg2, 8'd15);
        tick();
        tick();
        set_cdb(3'd4, 8'd15);
        tick();
        clr();

        // 3+4: fill, ignored issue while full, freeing broadcast feeds chain
        set_issue(0, 8'd3, 0, 8'd3);
        tick();
        set_issue(3'd4, 8'd0, 0, 8'd6);
        tick();
        check("t3_full", issue_ready, 0);
        check("t3_full_tag", issue_tag, 3'd0);
        set_issue(0, 8'd1, 0, 8'd1);
        tick();
        check("t3_ignored", rs_busy, 2'b11);
        clr();
        set_cdb(3'd4, 8'd10);
        tick();
        clr();
        check("t3_ready_again", issue_ready, 1);
        check("t3_tag_again", issue_tag, 3'd4);
        tick();
        check("t4_chain_tag", mul_tag_ip, 3'd5);
        check("t4_chain_src1", source_reg1, 8'd10);
        check("t4_chain_src2", source_reg2, 8'd6);
        tick();
        set_cdb(3'd5, 8'd60);
        tick();
        clr();
        check("t4_freed", rs_busy, 2'b00);

        // 5: same-cycle bypass at allocation
        set_issue(3'd2, 8'd99, 0, 8'd3);
        set_cdb(3'd2, 8'd7);
        tick();
        clr();
        tick();
        check("t5_disp_tag", mul_tag_ip, 3'd4);
        check("t5_src1", source_reg1, 8'd7);
        check("t5_src2", source_reg2, 8'd3);
        tick();
        set_cdb(3'd4, 8'd21);
        tick();
        clr();

        // 6: multiplier busy holds dispatch; async reset during ISSUE
        mul_status = 1;
        set_issue(0, 8'd8, 0, 8'd9);
        tick();
        clr();
        repeat (4) begin
            tick();
            check("t6_held", mul_tag_ip, 3'd0);
        end
        mul_status = 0;
        tick();
        check("t6_disp_tag", mul_tag_ip, 3'd4);
        check("t6_src1", source_reg1, 8'd8);
        rst_n = 0;
        #1;
        check("t6_async_tag", mul_tag_ip, 3'd0);
        check("t6_async_busy", rs_busy, 2'b00);
        check("t6_async_src1", source_reg1, 0);
        do_reset();

        // Randomized run; the bench answers each dispatch as the multiplier.
        res_due = -1;
        for (int k = 0; k < 600; k++) begin
            clr();
            mul_status = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 1) == 1) begin
                bit [2:0] a, b;
                a = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(1, 3));
                b = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(1, 3));
                set_issue(a, 8'($urandom), b, 8'($urandom));
            end
            if (res_due >= 0 && cycle >= res_due) begin
                set_cdb(res_tag, res_data);
                res_due = -1;
            end else if ($urandom_range(0, 2) == 0) begin
                int t;
                t = $urandom_range(0, 4);
                set_cdb((t < 3) ? 3'(t + 1) : 3'(t + 3), 8'($urandom));
            end
            tick();
            if (m_tag_ip != 3'd0) begin
                res_tag  = m_tag_ip;
                res_data = 8'(m_s1 * m_s2);
                res_due  = cycle + $urandom_range(1, 4);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
